// File: rtl/l2_mem_req_queue.sv
// l2_mem_req_queue
//   Request queue sitting directly upstream of the L2 AMBA bridge. Line-sized
//   read/write requests from the L2 cache core are buffered in a circular
//   FIFO. One request at a time is offered to the bridge. The single-beat
//   response is registered back to the cache.
//
//   Optional feature: define L2_MEMQ_STATS_EN to add saturating 16-bit
//   completion counters (o_cnt_rd, o_cnt_wr, o_cnt_fault).
//
// Ports
//   i_clk, i_rst           clock (rising edge), asynchronous active-high reset
//   o_req_ready / i_req_*  upstream push interface from the cache core
//   o_resp_*               registered response to the cache (one-cycle valid)
//   o_mem_req_* / i_mem_req_ready
//                          request to the bridge, always the head entry
//   i_mem_resp_*           bridge completion (ack) with read data and faults
//   o_dbg_state            current controller state (IDLE=0, ISSUE=1, WAIT=2)
//   o_cnt_*                completion statistics (L2_MEMQ_STATS_EN only)
//
// Handshakes: a push happens on a rising edge where i_req_valid && o_req_ready.
// The bridge takes a request on an edge where o_mem_req_valid && i_mem_req_ready.
// The request then completes on the first later edge with i_mem_resp_ack high.
// o_req_ready depends only on registered occupancy, never on a same-cycle pop.
module l2_mem_req_queue #(
   parameter int DEPTH_LOG2 = 2,
   localparam int REQ_MEM_TYPE_BITS = 3,
   localparam int REQ_MEM_TYPE_WRITE = 0,
   localparam int REQ_MEM_TYPE_CACHED = 1,
   localparam int CFG_CPU_ADDR_BITS = 32,
   localparam int L2CACHE_BYTES_PER_LINE = 32,
   localparam int L2CACHE_LINE_BITS = 8 * L2CACHE_BYTES_PER_LINE
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   output logic                              o_req_ready,
   input  logic                              i_req_valid,
   input  logic [REQ_MEM_TYPE_BITS-1:0]      i_req_type,
   input  logic [2:0]                        i_req_size,
   input  logic [2:0]                        i_req_prot,
   input  logic [CFG_CPU_ADDR_BITS-1:0]      i_req_addr,
   input  logic [L2CACHE_BYTES_PER_LINE-1:0] i_req_strob,
   input  logic [L2CACHE_LINE_BITS-1:0]      i_req_data,
   output logic                              o_resp_valid,
   output logic                              o_resp_write,
   output logic [L2CACHE_LINE_BITS-1:0]      o_resp_data,
   output logic                              o_resp_load_fault,
   output logic                              o_resp_store_fault,
   output logic                              o_mem_req_valid,
   input  logic                              i_mem_req_ready,
   output logic [REQ_MEM_TYPE_BITS-1:0]      o_mem_req_type,
   output logic [2:0]                        o_mem_req_size,
   output logic [2:0]                        o_mem_req_prot,
   output logic [CFG_CPU_ADDR_BITS-1:0]      o_mem_req_addr,
   output logic [L2CACHE_BYTES_PER_LINE-1:0] o_mem_req_strob,
   output logic [L2CACHE_LINE_BITS-1:0]      o_mem_req_data,
   input  logic                              i_mem_resp_valid,
   input  logic                              i_mem_resp_ack,
   input  logic [L2CACHE_LINE_BITS-1:0]      i_mem_resp_data,
   input  logic                              i_mem_resp_load_fault,
   input  logic                              i_mem_resp_store_fault,
   output logic [1:0]                        o_dbg_state
`ifdef L2_MEMQ_STATS_EN
   ,
   output logic [15:0]                       o_cnt_rd,
   output logic [15:0]                       o_cnt_wr,
   output logic [15:0]                       o_cnt_fault
`endif
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // Entry storage is deliberately left out of reset; only pointers/count are cleared.
   logic [REQ_MEM_TYPE_BITS-1:0]      ent_type  [DEPTH];
   logic [2:0]                        ent_size  [DEPTH];
   logic [2:0]                        ent_prot  [DEPTH];
   logic [CFG_CPU_ADDR_BITS-1:0]      ent_addr  [DEPTH];
   logic [L2CACHE_BYTES_PER_LINE-1:0] ent_strob [DEPTH];
   logic [L2CACHE_LINE_BITS-1:0]      ent_data  [DEPTH];

   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   state_t                state_q;
   state_t                state_d;
   logic                  push;
   logic                  pop;
   logic                  head_is_write;
   logic                  unused_resp_valid;

   // The bridge samples the head fields combinationally through its write
   // data phase; rd_ptr only moves on pop, so these are stable until the ack.
   assign o_mem_req_type  = ent_type[rd_ptr];
   assign o_mem_req_size  = ent_size[rd_ptr];
   assign o_mem_req_prot  = ent_prot[rd_ptr];
   assign o_mem_req_addr  = ent_addr[rd_ptr];
   assign o_mem_req_strob = ent_strob[rd_ptr];
   assign o_mem_req_data  = ent_data[rd_ptr];

   assign head_is_write     = ent_type[rd_ptr][REQ_MEM_TYPE_WRITE];
   assign o_req_ready       = (count != DEPTH_CNT);
   assign push              = i_req_valid && o_req_ready;
   assign o_dbg_state       = state_q;
   // Completion is driven by the ack alone; the valid strobe is informational.
   assign unused_resp_valid = i_mem_resp_valid;

   always_ff @(posedge i_clk) begin
      if (push) begin
         ent_type[wr_ptr]  <= i_req_type;
         ent_size[wr_ptr]  <= i_req_size;
         ent_prot[wr_ptr]  <= i_req_prot;
         ent_addr[wr_ptr]  <= i_req_addr;
         ent_strob[wr_ptr] <= i_req_strob;
         ent_data[wr_ptr]  <= i_req_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // An ack seen outside WAIT is ignored: no pop and no response.
   always_comb begin
      state_d         = state_q;
      o_mem_req_valid = 1'b0;
      pop             = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count != '0) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            o_mem_req_valid = 1'b1;
            if (i_mem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_mem_resp_ack) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Read data is only refreshed by reads; a write leaves the last line visible.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_resp_valid       <= 1'b0;
         o_resp_write       <= 1'b0;
         o_resp_data        <= '0;
         o_resp_load_fault  <= 1'b0;
         o_resp_store_fault <= 1'b0;
      end else begin
         o_resp_valid <= pop;
         if (pop) begin
            o_resp_write       <= head_is_write;
            o_resp_load_fault  <= i_mem_resp_load_fault;
            o_resp_store_fault <= i_mem_resp_store_fault;
            if (!head_is_write) begin
               o_resp_data <= i_mem_resp_data;
            end
         end
      end
   end

`ifdef L2_MEMQ_STATS_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_cnt_rd    <= '0;
         o_cnt_wr    <= '0;
         o_cnt_fault <= '0;
      end else if (pop) begin
         if (head_is_write && (o_cnt_wr != 16'hFFFF)) begin
            o_cnt_wr <= o_cnt_wr + 16'd1;
         end
         if (!head_is_write && (o_cnt_rd != 16'hFFFF)) begin
            o_cnt_rd <= o_cnt_rd + 16'd1;
         end
         if ((i_mem_resp_load_fault || i_mem_resp_store_fault) && (o_cnt_fault != 16'hFFFF)) begin
            o_cnt_fault <= o_cnt_fault + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_l2_mem_req_queue.sv
// tb_l2_mem_req_queue
//   Bench for l2_mem_req_queue (default DEPTH_LOG2=2, four entries). It runs
//   directed scenarios and then random traffic. A transaction-level model
//   (request queue + offered/accepted flags) predicts every output each cycle.
//   Build with L2_MEMQ_STATS_EN defined to also cover the statistics counters.
module tb_l2_mem_req_queue;

   localparam int DEPTH = 4;
   localparam int TB_W  = 256;

   typedef struct {
      logic [2:0]   typ;
      logic [2:0]   size;
      logic [2:0]   prot;
      logic [31:0]  addr;
      logic [31:0]  strob;
      logic [255:0] data;
   } req_t;

   // ---------------- clock / reset ----------------
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   // ---------------- DUT signals ----------------
   logic         o_req_ready;
   logic         i_req_valid = 1'b0;
   logic [2:0]   i_req_type = '0;
   logic [2:0]   i_req_size = '0;
   logic [2:0]   i_req_prot = '0;
   logic [31:0]  i_req_addr = '0;
   logic [31:0]  i_req_strob = '0;
   logic [255:0] i_req_data = '0;
   logic         o_resp_valid;
   logic         o_resp_write;
   logic [255:0] o_resp_data;
   logic         o_resp_load_fault;
   logic         o_resp_store_fault;
   logic         o_mem_req_valid;
   logic         i_mem_req_ready = 1'b0;
   logic [2:0]   o_mem_req_type;
   logic [2:0]   o_mem_req_size;
   logic [2:0]   o_mem_req_prot;
   logic [31:0]  o_mem_req_addr;
   logic [31:0]  o_mem_req_strob;
   logic [255:0] o_mem_req_data;
   logic         i_mem_resp_valid = 1'b0;
   logic         i_mem_resp_ack = 1'b0;
   logic [255:0] i_mem_resp_data = '0;
   logic         i_mem_resp_load_fault = 1'b0;
   logic         i_mem_resp_store_fault = 1'b0;
   logic [1:0]   o_dbg_state;
`ifdef L2_MEMQ_STATS_EN
   logic [15:0]  o_cnt_rd;
   logic [15:0]  o_cnt_wr;
   logic [15:0]  o_cnt_fault;
`endif

   l2_mem_req_queue #(.DEPTH_LOG2(2)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .o_req_ready(o_req_ready),
      .i_req_valid(i_req_valid),
      .i_req_type(i_req_type),
      .i_req_size(i_req_size),
      .i_req_prot(i_req_prot),
      .i_req_addr(i_req_addr),
      .i_req_strob(i_req_strob),
      .i_req_data(i_req_data),
      .o_resp_valid(o_resp_valid),
      .o_resp_write(o_resp_write),
      .o_resp_data(o_resp_data),
      .o_resp_load_fault(o_resp_load_fault),
      .o_resp_store_fault(o_resp_store_fault),
      .o_mem_req_valid(o_mem_req_valid),
      .i_mem_req_ready(i_mem_req_ready),
      .o_mem_req_type(o_mem_req_type),
      .o_mem_req_size(o_mem_req_size),
      .o_mem_req_prot(o_mem_req_prot),
      .o_mem_req_addr(o_mem_req_addr),
      .o_mem_req_strob(o_mem_req_strob),
      .o_mem_req_data(o_mem_req_data),
      .i_mem_resp_valid(i_mem_resp_valid),
      .i_mem_resp_ack(i_mem_resp_ack),
      .i_mem_resp_data(i_mem_resp_data),
      .i_mem_resp_load_fault(i_mem_resp_load_fault),
      .i_mem_resp_store_fault(i_mem_resp_store_fault),
      .o_dbg_state(o_dbg_state)
`ifdef L2_MEMQ_STATS_EN
      ,
      .o_cnt_rd(o_cnt_rd),
      .o_cnt_wr(o_cnt_wr),
      .o_cnt_fault(o_cnt_fault)
`endif
   );

   // ---------------- scoreboard / reference model ----------------
   int n_checks = 0;
   int n_fail   = 0;

   req_t         exp_q[$];   // requests held by the queue, head first
   bit           m_offer;    // head currently offered to the bridge
   bit           m_accepted; // head taken by the bridge, awaiting ack
   bit           m_resp_valid;
   bit           m_resp_write;
   logic [255:0] m_resp_data;
   bit           m_lf;
   bit           m_sf;
   int           m_cnt_rd;
   int           m_cnt_wr;
   int           m_cnt_fault;

   task automatic check_eq(input string tag, input logic [TB_W-1:0] act, input logic [TB_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_offer      = 1'b0;
      m_accepted   = 1'b0;
      m_resp_valid = 1'b0;
      m_resp_write = 1'b0;
      m_resp_data  = '0;
      m_lf         = 1'b0;
      m_sf         = 1'b0;
      m_cnt_rd     = 0;
      m_cnt_wr     = 0;
      m_cnt_fault  = 0;
   endtask

   // Advance the model by one rising edge using the inputs held during the
   // cycle that just ended.
   task automatic model_edge();
      req_t h;
      bit   push_ok;
      if (i_rst) begin
         model_reset();
         return;
      end
      push_ok      = i_req_valid && (exp_q.size() != DEPTH);
      m_resp_valid = 1'b0;
      if (m_accepted && i_mem_resp_ack) begin
         h            = exp_q.pop_front();
         m_accepted   = 1'b0;
         m_resp_valid = 1'b1;
         m_resp_write = h.typ[0];
         m_lf         = i_mem_resp_load_fault;
         m_sf         = i_mem_resp_store_fault;
         if (!h.typ[0]) m_resp_data = i_mem_resp_data;
         if (h.typ[0] && m_cnt_wr < 65535) m_cnt_wr++;
         if (!h.typ[0] && m_cnt_rd < 65535) m_cnt_rd++;
         if ((i_mem_resp_load_fault || i_mem_resp_store_fault) && m_cnt_fault < 65535) m_cnt_fault++;
      end else if (m_offer && i_mem_req_ready) begin
         m_offer    = 1'b0;
         m_accepted = 1'b1;
      end else if (!m_offer && !m_accepted && exp_q.size() != 0) begin
         m_offer = 1'b1;
      end
      if (push_ok) begin
         h.typ   = i_req_type;
         h.size  = i_req_size;
         h.prot  = i_req_prot;
         h.addr  = i_req_addr;
         h.strob = i_req_strob;
         h.data  = i_req_data;
         exp_q.push_back(h);
      end
   endtask

   task automatic check_all();
      check_eq("req_ready", o_req_ready, exp_q.size() != DEPTH);
      check_eq("mem_req_valid", o_mem_req_valid, m_offer);
      if (exp_q.size() != 0) begin
         check_eq("head_type", o_mem_req_type, exp_q[0].typ);
         check_eq("head_size", o_mem_req_size, exp_q[0].size);
         check_eq("head_prot", o_mem_req_prot, exp_q[0].prot);
         check_eq("head_addr", o_mem_req_addr, exp_q[0].addr);
         check_eq("head_strob", o_mem_req_strob, exp_q[0].strob);
         check_eq("head_data", o_mem_req_data, exp_q[0].data);
      end
      check_eq("resp_valid", o_resp_valid, m_resp_valid);
      check_eq("resp_write", o_resp_write, m_resp_write);
      check_eq("resp_data", o_resp_data, m_resp_data);
      check_eq("resp_load_fault", o_resp_load_fault, m_lf);
      check_eq("resp_store_fault", o_resp_store_fault, m_sf);
`ifdef L2_MEMQ_STATS_EN
      check_eq("cnt_rd", o_cnt_rd, 16'(m_cnt_rd));
      check_eq("cnt_wr", o_cnt_wr, 16'(m_cnt_wr));
      check_eq("cnt_fault", o_cnt_fault, 16'(m_cnt_fault));
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge i_clk);
      #1;
      model_edge();
      check_all();
   endtask

   function automatic logic [255:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle_inputs();
      i_req_valid            = 1'b0;
      i_mem_req_ready        = 1'b0;
      i_mem_resp_ack         = 1'b0;
      i_mem_resp_valid       = 1'b0;
      i_mem_resp_load_fault  = 1'b0;
      i_mem_resp_store_fault = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      step();
   endtask

   task automatic set_req(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] strob,
                          input logic [255:0] data);
      i_req_valid = 1'b1;
      i_req_type  = typ;
      i_req_size  = 3'd5;
      i_req_prot  = 3'($urandom_range(0, 7));
      i_req_addr  = addr;
      i_req_strob = strob;
      i_req_data  = data;
   endtask

   task automatic push_req(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] strob,
                           input logic [255:0] data);
      set_req(typ, addr, strob, data);
      step();
      i_req_valid = 1'b0;
   endtask

   task automatic wait_offer();
      for (int i = 0; i < 10 && !o_mem_req_valid; i++) step();
      if (!o_mem_req_valid) check_eq("wait_offer_timeout", 1'b0, 1'b1);
   endtask

   // Bridge takes the offered head, then acks it lat cycles after acceptance.
   task automatic complete_head(input int lat, input logic [255:0] d, input logic lf, input logic sf);
      i_mem_req_ready = 1'b1;
      step();
      i_mem_req_ready = 1'b0;
      repeat (lat - 1) step();
      i_mem_resp_ack         = 1'b1;
      i_mem_resp_valid       = 1'b1;
      i_mem_resp_data        = d;
      i_mem_resp_load_fault  = lf;
      i_mem_resp_store_fault = sf;
      step();
      idle_inputs();
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++) begin
         wait_offer();
         complete_head(2, rand_line(), 1'b0, 1'b0);
      end
      step();
   endtask

   // ---------------- stimulus ----------------
   logic [255:0] line_d;

   initial begin
      model_reset();

      // Reset state
      apply_reset();
      check_eq("rst_req_ready", o_req_ready, 1'b1);
      check_eq("rst_mem_req_valid", o_mem_req_valid, 1'b0);
      check_eq("rst_resp_valid", o_resp_valid, 1'b0);
      check_eq("rst_resp_data", o_resp_data, '0);
      check_eq("rst_dbg_state", o_dbg_state, 2'd0);

      // Single read: first offer one cycle after the push edge
      push_req(3'b010, 32'h8000_1000, 32'h0, '0);
      check_eq("rd_not_yet_offered", o_mem_req_valid, 1'b0);
      step();
      check_eq("rd_offered", o_mem_req_valid, 1'b1);
      check_eq("rd_addr", o_mem_req_addr, 32'h8000_1000);
      complete_head(3, {32{8'hA5}}, 1'b0, 1'b0);
      check_eq("rd_resp_valid", o_resp_valid, 1'b1);
      check_eq("rd_resp_write", o_resp_write, 1'b0);
      check_eq("rd_resp_data", o_resp_data, {32{8'hA5}});
      check_eq("rd_resp_faults", {o_resp_load_fault, o_resp_store_fault}, 2'b00);
      step();
      check_eq("rd_resp_one_cycle", o_resp_valid, 1'b0);
      check_eq("rd_queue_empty", o_req_ready, 1'b1);

      // Write hold: head fields stable until the ack
      line_d = rand_line();
      push_req(3'b001, 32'h0000_2000, 32'hFFFF_FFFF, line_d);
      wait_offer();
      i_mem_req_ready = 1'b1;
      step();
      i_mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("wr_hold_addr", o_mem_req_addr, 32'h0000_2000);
         check_eq("wr_hold_strob", o_mem_req_strob, 32'hFFFF_FFFF);
         check_eq("wr_hold_data", o_mem_req_data, line_d);
      end
      i_mem_resp_ack = 1'b1;
      step();
      i_mem_resp_ack = 1'b0;
      check_eq("wr_resp_write", o_resp_write, 1'b1);
      check_eq("wr_resp_data_kept", o_resp_data, {32{8'hA5}});
      step();

      // Fill and wrap: six pushes against a stalled bridge
      for (int i = 0; i < 6; i++) begin
         set_req(3'($urandom_range(0, 7)), 32'h3000 + 32'(i * 64), $urandom, rand_line());
         step();
         if (i == 3) check_eq("fill_full_not_ready", o_req_ready, 1'b0);
      end
      i_req_valid = 1'b0;
      check_eq("fill_count", exp_q.size(), DEPTH);
      drain();

      // Simultaneous push and pop at full
      for (int i = 0; i < DEPTH; i++) begin
         set_req(3'($urandom_range(0, 7)), 32'h4000 + 32'(i * 64), $urandom, rand_line());
         step();
      end
      i_req_valid = 1'b0;
      wait_offer();
      i_mem_req_ready = 1'b1;
      step();
      i_mem_req_ready = 1'b0;
      set_req(3'b000, 32'h4F00, 32'h0, '0);
      i_mem_resp_ack  = 1'b1;
      i_mem_resp_data = rand_line();
      check_eq("full_pop_push_not_ready", o_req_ready, 1'b0);
      step();
      idle_inputs();
      check_eq("after_pop_ready", o_req_ready, 1'b1);
      check_eq("after_pop_count", exp_q.size(), 3);
      drain();

      // Faults and statistics
      apply_reset();
      push_req(3'b000, 32'h5000, 32'h0, '0);
      push_req(3'b001, 32'h5040, 32'hFFFF_FFFF, rand_line());
      wait_offer();
      complete_head(2, rand_line(), 1'b1, 1'b0);
      check_eq("load_fault", o_resp_load_fault, 1'b1);
      check_eq("load_fault_store_clear", o_resp_store_fault, 1'b0);
      wait_offer();
      complete_head(2, rand_line(), 1'b0, 1'b1);
      check_eq("store_fault", o_resp_store_fault, 1'b1);
      check_eq("store_fault_load_clear", o_resp_load_fault, 1'b0);
`ifdef L2_MEMQ_STATS_EN
      check_eq("stat_fault", o_cnt_fault, 16'd2);
      check_eq("stat_rd", o_cnt_rd, 16'd1);
      check_eq("stat_wr", o_cnt_wr, 16'd1);
`endif
      step();

      // Asynchronous reset in the middle of WAIT
      push_req(3'b000, 32'h6000, 32'h0, '0);
      wait_offer();
      i_mem_req_ready = 1'b1;
      step();
      i_mem_req_ready = 1'b0;
      #3;
      i_rst = 1'b1;
      #1;
      model_reset();
      check_eq("async_rst_mem_req_valid", o_mem_req_valid, 1'b0);
      check_eq("async_rst_req_ready", o_req_ready, 1'b1);
      check_eq("async_rst_resp_valid", o_resp_valid, 1'b0);
      step();
      i_rst          = 1'b0;
      i_mem_resp_ack = 1'b1;
      step();
      i_mem_resp_ack = 1'b0;
      check_eq("stale_ack_no_resp", o_resp_valid, 1'b0);
      step();

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         i_req_valid            = ($urandom_range(0, 99) < 45);
         i_req_type             = 3'($urandom_range(0, 7));
         i_req_size             = 3'($urandom_range(0, 7));
         i_req_prot             = 3'($urandom_range(0, 7));
         i_req_addr             = $urandom;
         i_req_strob            = $urandom;
         i_req_data             = rand_line();
         i_mem_req_ready        = ($urandom_range(0, 99) < 50);
         i_mem_resp_ack         = ($urandom_range(0, 99) < 35);
         i_mem_resp_valid       = i_mem_resp_ack;
         i_mem_resp_data        = rand_line();
         i_mem_resp_load_fault  = ($urandom_range(0, 99) < 10);
         i_mem_resp_store_fault = ($urandom_range(0, 99) < 10);
         step();
      end
      idle_inputs();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
